// File: rtl/td4_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | td4_ctrl_pkg : shared encodings for the TD4 run controller        |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package td4_ctrl_pkg;

  typedef enum logic [1:0] {
    S_LOAD = 2'b00,
    S_HALT = 2'b01,
    S_RUN  = 2'b10,
    S_STEP = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    CMD_LOAD = 2'b00,
    CMD_RUN  = 2'b01,
    CMD_STEP = 2'b10,
    CMD_HALT = 2'b11
  } cmd_t;

  localparam logic [3:0] OP_JMP     = 4'b1111;
  localparam int         PROG_DEPTH = 16;

endpackage
`default_nettype wire

// File: rtl/td4_prog_mem.sv
`default_nettype none
// +------------------------------------------------------------------+
// | td4_prog_mem : 16x8 program store, sync write, async read,        |
// |                async active-low clear                             |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module td4_prog_mem
  import td4_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [3:0] waddr,
  input  logic [7:0] wdata,
  input  logic [3:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] r_mem [PROG_DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PROG_DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/td4_run_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | td4_run_ctrl : load/halt/run/step sequencer for the TD4 datapath  |
// | Option: TD4_SELF_JUMP_HALT_EN halts on a "jmp to self" in RUN/STEP|
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module td4_run_ctrl
  import td4_ctrl_pkg::*;
#(
  parameter int RUN_DIV = 0,
  parameter int DIV_W   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic       ld_valid,
  output logic       ld_ready,
  input  logic [7:0] ld_data,
  input  logic [3:0] pc,
  input  logic       pc_co,
  output logic [7:0] instr,
  output logic       cpu_en,
  output logic       cpu_rst_n,
  output logic [1:0] state_o,
  output logic       halted
);

  localparam logic [DIV_W-1:0] c_run_div = DIV_W'(RUN_DIV);

  state_t           r_state, w_state_nx;
  logic [3:0]       r_ld_addr, w_ld_addr_nx;
  logic [DIV_W-1:0] r_div_cnt, w_div_cnt_nx;
  logic             r_cpu_rst_n;
  logic             w_cmd_acc, w_ld_acc, w_self_jmp, w_div_hit;

  assign cmd_ready = (r_state != S_STEP);
  assign ld_ready  = (r_state == S_LOAD);
  assign halted    = (r_state == S_HALT);
  assign state_o   = r_state;
  assign cpu_rst_n = r_cpu_rst_n;
  assign w_cmd_acc = cmd_valid & cmd_ready;
  assign w_ld_acc  = ld_valid & ld_ready;
  assign w_div_hit = (r_div_cnt == c_run_div);

`ifdef TD4_SELF_JUMP_HALT_EN
  assign w_self_jmp = (instr[7:4] == OP_JMP) && (instr[3:0] == pc);
`else
  assign w_self_jmp = 1'b0;
`endif

  td4_prog_mem u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (w_ld_acc),
    .waddr (r_ld_addr),
    .wdata (ld_data),
    .raddr (pc),
    .rdata (instr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_LOAD;
      r_ld_addr   <= 4'h0;
      r_div_cnt   <= '0;
      r_cpu_rst_n <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_ld_addr   <= w_ld_addr_nx;
      r_div_cnt   <= w_div_cnt_nx;
      r_cpu_rst_n <= (w_state_nx != S_LOAD);
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_ld_addr_nx = w_ld_acc ? r_ld_addr + 4'd1 : r_ld_addr;
    w_div_cnt_nx = r_div_cnt;
    cpu_en       = 1'b0;

    unique case (r_state)
      S_LOAD: begin
        if (w_ld_acc && (r_ld_addr == 4'hF)) w_state_nx = S_HALT;
      end
      S_RUN: begin
        w_div_cnt_nx = w_div_hit ? '0 : r_div_cnt + DIV_W'(1);
        if (w_self_jmp || pc_co) w_state_nx = S_HALT;
        else if (w_div_hit)      cpu_en     = 1'b1;
      end
      S_STEP: begin
        w_state_nx = S_HALT;
        cpu_en     = !pc_co && !w_self_jmp;
      end
      default: ;
    endcase

    // Commands override the mode's own transition; a same-cycle byte is still written.
    if (w_cmd_acc) begin
      unique case (cmd)
        CMD_LOAD: begin
          w_state_nx   = S_LOAD;
          w_ld_addr_nx = 4'h0;
        end
        CMD_RUN: begin
          if (r_state != S_RUN) begin
            w_state_nx   = S_RUN;
            w_div_cnt_nx = '0;
          end
        end
        CMD_STEP: begin
          if (r_state != S_RUN) w_state_nx = S_STEP;
        end
        default: begin
          w_state_nx = S_HALT;
          cpu_en     = 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
